// File: rtl/regfile_writeback_pkg.sv
// Shared constants for the register file and its writeback initiator.
package regfile_writeback_pkg;

  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 5;
  localparam int REG_COUNT = 32;

  localparam logic [ADDR_W-1:0] X0 = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// Small power-of-two FIFO holding pending writebacks; push/pop are masked by full/empty.
module wb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 69,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback initiator: mem>alu arbitration into a FIFO, registered write port,
// and a per-register pending scoreboard for decode hazard checks.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int OCC_W  = $clog2(DEPTH) + 1,
  localparam int PEND_W = $clog2(DEPTH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              drain_en,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] RS1,
  input  logic [ADDR_W-1:0] RS2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [OCC_W-1:0]  occupancy
);

  wb_entry_t              w_push_entry, w_head;
  logic                   w_full, w_empty;
  logic                   w_mem_acc, w_alu_acc, w_push, w_pop;
  logic [REG_COUNT-1:0]   w_busy;

  // Ready uses the pre-edge count, so a full FIFO never accepts on a pop edge.
  assign mem_ready = reset & ~w_full;
  assign alu_ready = reset & ~w_full & ~mem_valid;
  assign w_mem_acc = mem_valid & mem_ready;
  assign w_alu_acc = alu_valid & alu_ready;

  assign w_push_entry = w_mem_acc ? wb_entry_t'{rd: mem_rd, data: mem_data}
                                  : wb_entry_t'{rd: alu_rd, data: alu_data};
  assign w_push = (w_mem_acc | w_alu_acc) & (w_push_entry.rd != X0);
  assign w_pop  = ~w_empty & drain_en;

  wb_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(wb_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (occupancy)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      RegWrite <= w_pop;
      if (w_pop) begin
        RD        <= w_head.rd;
        WriteData <= w_head.data;
      end
    end
  end

  // Counter covers FIFO entries plus the output stage, so DEPTH+1 must fit.
  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < REG_COUNT; r++) begin : g_pend
    logic [PEND_W-1:0] r_pend;
    logic              w_inc, w_dec;

    assign w_inc = w_push & (w_push_entry.rd == ADDR_W'(r));
    assign w_dec = RegWrite & (RD == ADDR_W'(r));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)            r_pend <= '0;
      else if (w_inc & ~w_dec) r_pend <= r_pend + 1'b1;
      else if (w_dec & ~w_inc) r_pend <= r_pend - 1'b1;
    end

    assign w_busy[r] = |r_pend;
  end

  assign rs1_busy = w_busy[RS1];
  assign rs2_busy = w_busy[RS2];

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: arbitration, latency, ordering, scoreboard, reset.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int DEPTH = 4;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              clk, reset;
  logic              alu_valid, mem_valid, drain_en;
  logic [ADDR_W-1:0] alu_rd, mem_rd, RS1, RS2, RD;
  logic [DATA_W-1:0] alu_data, mem_data, WriteData;
  logic              alu_ready, mem_ready, RegWrite, rs1_busy, rs2_busy;
  logic [OCC_W-1:0]  occupancy;

  int n_vec = 0;
  int n_err = 0;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .drain_en(drain_en), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .RS1(RS1), .RS2(RS2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_push(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    tick();
    alu_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; drain_en = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 64'h11;
    RS1 = 5'd1; RS2 = 5'd0;

    // 1: reset holds everything quiet
    tick();
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_alu_ready", alu_ready, 0);
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_rs1_busy", rs1_busy, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_rd", RD, 0);
    chk("rst_wdata", WriteData, 0);
    mem_valid = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_write", RegWrite, 0);
    end

    // 2: single ALU result, one-cycle latency and busy window
    RS1 = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hAA;
    #1;
    chk("t2_alu_ready", alu_ready, 1);
    chk("t2_busy_pre", rs1_busy, 0);
    tick();
    alu_valid = 1'b0;
    chk("t2_n_regwrite", RegWrite, 0);
    chk("t2_n_busy", rs1_busy, 1);
    chk("t2_n_occ", occupancy, 1);
    tick();
    chk("t2_n1_regwrite", RegWrite, 1);
    chk("t2_n1_rd", RD, 5);
    chk("t2_n1_wdata", WriteData, 64'hAA);
    chk("t2_n1_busy", rs1_busy, 1);
    chk("t2_n1_occ", occupancy, 0);
    tick();
    chk("t2_n2_regwrite", RegWrite, 0);
    chk("t2_n2_busy", rs1_busy, 0);

    // 3: mem wins over alu, order preserved
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 64'h33;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
    #1;
    chk("t3_mem_ready", mem_ready, 1);
    chk("t3_alu_blocked", alu_ready, 0);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("t3_alu_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    chk("t3_w1_regwrite", RegWrite, 1);
    chk("t3_w1_rd", RD, 3);
    chk("t3_w1_wdata", WriteData, 64'h33);
    tick();
    chk("t3_w2_regwrite", RegWrite, 1);
    chk("t3_w2_rd", RD, 4);
    chk("t3_w2_wdata", WriteData, 64'h44);
    tick();
    chk("t3_idle", RegWrite, 0);

    // 4: fill with drain stalled, then drain in order; no accept on full+pop edge
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) alu_push(5'(10 + i), 64'(256 + i));
    chk("t4_occ_full", occupancy, 4);
    chk("t4_mem_ready", mem_ready, 0);
    chk("t4_alu_ready", alu_ready, 0);
    chk("t4_stalled", RegWrite, 0);
    drain_en = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 64'hDEAD;
    RS2 = 5'd20;
    #1;
    chk("t4_full_pop_ready", mem_ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_valid = 1'b0;
      chk("t4_drain_we", RegWrite, 1);
      chk("t4_drain_rd", RD, 64'(10 + i));
      chk("t4_drain_wdata", WriteData, 64'(256 + i));
    end
    chk("t4_occ_empty", occupancy, 0);
    chk("t4_rs2_not_busy", rs2_busy, 0);
    tick();
    chk("t4_no_extra", RegWrite, 0);

    // 5: two writes to x7, busy until the second commit, last value wins
    RS1 = 5'd7;
    alu_push(5'd7, 64'h1);
    chk("t5_busy_a", rs1_busy, 1);
    alu_push(5'd7, 64'h2);
    chk("t5_w1_wdata", WriteData, 64'h1);
    chk("t5_busy_b", rs1_busy, 1);
    tick();
    chk("t5_w2_wdata", WriteData, 64'h2);
    chk("t5_busy_c", rs1_busy, 1);
    tick();
    chk("t5_done_we", RegWrite, 0);
    chk("t5_busy_d", rs1_busy, 0);
    chk("t5_final", WriteData, 64'h2);

    // 6: x0 is accepted but dropped
    RS1 = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 64'hFF;
    #1;
    chk("t6_x0_ready", mem_ready, 1);
    tick();
    mem_valid = 1'b0;
    chk("t6_x0_occ", occupancy, 0);
    chk("t6_x0_busy", rs1_busy, 0);
    tick();
    chk("t6_x0_no_write", RegWrite, 0);

    // async reset with entries in flight
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) alu_push(5'(1 + i), 64'(16 + i));
    RS1 = 5'd2;
    drain_en = 1'b1;
    tick();
    chk("t6_pre_we", RegWrite, 1);
    chk("t6_pre_occ", occupancy, 3);
    chk("t6_pre_busy", rs1_busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_occ", occupancy, 0);
    chk("t6_async_we", RegWrite, 0);
    chk("t6_async_busy", rs1_busy, 0);
    chk("t6_async_rd", RD, 0);
    #1;
    reset = 1'b1;
    tick();
    chk("t6_after_rst_we", RegWrite, 0);
    chk("t6_after_rst_occ", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
